// File: rtl/demux1to8_n_if.sv
// Input channel and per-channel output buffers of the 1-to-m demultiplexer.
// The slave modport is the demultiplexer's view; master is the producer/consumer side.
interface demux1to8_n_if #(
  parameter int unsigned n       = 4,
  parameter int unsigned address = 3,
  parameter int unsigned m       = 8
);
  logic [n-1:0]       data_i;
  logic               valid_i;
  logic [address-1:0] sel;
  logic               ready_o;
  logic [n-1:0]       data_o [m];
  logic [m-1:0]       valid_o;
  logic [m-1:0]       ready_i;
  logic               err_o;
  logic [7:0]         drop_cnt_o;

  modport slave (
    input  data_i, valid_i, sel, ready_i,
    output ready_o, data_o, valid_o, err_o, drop_cnt_o
  );

  modport master (
    output data_i, valid_i, sel, ready_i,
    input  ready_o, data_o, valid_o, err_o, drop_cnt_o
  );
endinterface

// File: rtl/demux1to8_n.sv
// Registered 1-to-m demultiplexer: steers each accepted word by sel into one of
// m single-entry buffers that drain independently; out-of-range words are dropped and counted.
module demux1to8_n #(
  parameter int unsigned n       = 4,
  parameter int unsigned address = 3,
  parameter int unsigned m       = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  demux1to8_n_if.slave  bus
);
  localparam int unsigned CNT_W = 8;

  logic [m-1:0]     v;
  logic [n-1:0]     d [m];
  logic [m-1:0]     hit;
  logic [m-1:0]     take;
  logic             in_range;
  logic             ready_c;
  logic             accept;
  logic             drop;
  logic             err;
  logic [CNT_W-1:0] drop_cnt;

  // Destination decode; a full channel still accepts when its consumer drains this cycle.
  always_comb begin
    hit      = '0;
    in_range = (32'(bus.sel) < m);
    for (int unsigned k = 0; k < m; k++) begin
      hit[k] = in_range && (32'(bus.sel) == k);
    end
    ready_c = in_range ? |(hit & (~v | bus.ready_i)) : 1'b1;
  end

  assign accept = bus.valid_i && ready_c;
  assign take   = hit & {m{accept}};
  assign drop   = accept && !in_range;

  // Channel buffers: fill wins over drain so back-to-back words see no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v <= '0;
      for (int unsigned k = 0; k < m; k++) begin
        d[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < m; k++) begin
        if (take[k]) begin
          d[k] <= bus.data_i;
          v[k] <= 1'b1;
        end else if (bus.ready_i[k]) begin
          v[k] <= 1'b0;
        end
      end
    end
  end

  // Drop reporting: one err pulse per discarded word, saturating drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err <= drop;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ready_o    = ready_c;
  assign bus.valid_o    = v;
  assign bus.err_o      = err;
  assign bus.drop_cnt_o = drop_cnt;

  for (genvar k = 0; k < int'(m); k++) begin : g_out
    assign bus.data_o[k] = d[k];
  end
endmodule

// File: tb/tb_demux1to8_n.sv
// Scoreboard bench for demux1to8_n: an m=8 and an m=6 instance share one stimulus stream;
// each channel is modelled as a capacity-one queue, drops by a saturating counter.
module tb_demux1to8_n;
  localparam int unsigned N  = 4;
  localparam int unsigned A  = 3;
  localparam int unsigned M0 = 8;
  localparam int unsigned M1 = 6;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] data;
  logic         valid;
  logic [A-1:0] sel;
  logic [7:0]   rdy;

  always #5 clk = ~clk;

  demux1to8_n_if #(.n(N), .address(A), .m(M0)) if8 ();
  demux1to8_n_if #(.n(N), .address(A), .m(M1)) if6 ();

  assign if8.data_i  = data;
  assign if8.valid_i = valid;
  assign if8.sel     = sel;
  assign if8.ready_i = rdy;
  assign if6.data_i  = data;
  assign if6.valid_i = valid;
  assign if6.sel     = sel;
  assign if6.ready_i = rdy[5:0];

  demux1to8_n #(.n(N), .address(A), .m(M0)) dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(if8));
  demux1to8_n #(.n(N), .address(A), .m(M1)) dut6 (.clk_i(clk), .rst_ni(rst_n), .bus(if6));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: words held per (dut, channel); pend marks words pushed this cycle, not yet latched.
  logic [N-1:0] q    [16][$];
  logic         pend [16];
  logic [8:0]   fq   [2][$];
  int           m_drop [2];

  function automatic int mm(input int d);
    return (d == 0) ? int'(M0) : int'(M1);
  endfunction

  function automatic logic [7:0] vld(input int d);
    return (d == 0) ? if8.valid_o : 8'(if6.valid_o);
  endfunction

  function automatic logic rdy_act(input int d);
    return (d == 0) ? if8.ready_o : if6.ready_o;
  endfunction

  function automatic logic [N-1:0] dat(input int d, input int k);
    if (d == 0) return if8.data_o[k];
    if (k < int'(M1)) return if6.data_o[k];
    return '0;
  endfunction

  function automatic logic [8:0] flags(input int d);
    return (d == 0) ? {if8.err_o, if8.drop_cnt_o} : {if6.err_o, if6.drop_cnt_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      q[i].delete();
      pend[i] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      fq[d].delete();
      m_drop[d] = 0;
    end
  endtask

  task automatic zero_check();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst valid_o dut%0d", d), 32'(vld(d)), 32'd0);
      check($sformatf("rst err/drop dut%0d", d), 32'(flags(d)), 32'd0);
      for (int k = 0; k < mm(d); k++) begin
        check($sformatf("rst data_o[%0d] dut%0d", k, d), 32'(dat(d, k)), 32'd0);
      end
    end
  endtask

  // One clock of stimulus: drive after the edge, check ready_o and record the model's accept.
  task automatic cycle(input logic v, input logic [A-1:0] s, input logic [N-1:0] w,
                       input logic [7:0] r);
    @(posedge clk);
    #1;
    valid = v;
    sel   = s;
    data  = w;
    rdy   = r;
    for (int i = 0; i < 16; i++) pend[i] = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      logic inr;
      logic er;
      logic e;
      int   idx;
      idx = d * 8 + int'(s);
      inr = (int'(s) < mm(d));
      er  = !inr || (q[idx].size() == 0) || r[s];
      check($sformatf("ready_o dut%0d sel%0d", d, s), 32'(rdy_act(d)), 32'(er));
      e = v && er && !inr;
      if (v && er && inr) begin
        q[idx].push_back(w);
        pend[idx] = 1'b1;
      end
      if (e && (m_drop[d] < 255)) m_drop[d]++;
      fq[d].push_back({e, 8'(m_drop[d])});
    end
  endtask

  // Asynchronous reset between edges with the outputs checked before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    valid = 1'b0;
    rdy   = '0;
    #3;
    rst_n = 1'b0;
    #1;
    zero_check();
    clear_model();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare occupancy, pop and compare each drained word, and the err/drop state.
  always @(negedge clk) begin
    logic [7:0]   ev;
    logic [N-1:0] w;
    logic [8:0]   f;
    int           idx;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        ev = '0;
        for (int k = 0; k < mm(d); k++) begin
          idx   = d * 8 + k;
          ev[k] = (q[idx].size() - int'(pend[idx])) > 0;
        end
        check($sformatf("valid_o dut%0d", d), 32'(vld(d)), 32'(ev));
        for (int k = 0; k < mm(d); k++) begin
          idx = d * 8 + k;
          if (ev[k] && rdy[k]) begin
            w = q[idx].pop_front();
            check($sformatf("data_o[%0d] dut%0d", k, d), 32'(dat(d, k)), 32'(w));
          end
        end
        if (fq[d].size() >= 2) begin
          f = fq[d].pop_front();
          check($sformatf("err_o dut%0d", d), 32'(flags(d) >> 8), 32'(f >> 8));
          check($sformatf("drop_cnt_o dut%0d", d), 32'(flags(d) & 9'h0FF), 32'(f & 9'h0FF));
        end
      end
    end
  end

  initial begin
    valid = 1'b0;
    sel   = '0;
    data  = '0;
    rdy   = '0;
    clear_model();
    #2;
    zero_check();
    #5;
    rst_n = 1'b1;

    // Route one word, then backpressure and channel independence.
    cycle(1'b1, 3'd5, 4'h3, 8'h00);
    cycle(1'b0, 3'd0, 4'h0, 8'h00);
    cycle(1'b1, 3'd2, 4'hA, 8'h00);
    cycle(1'b1, 3'd2, 4'hB, 8'h00);
    cycle(1'b1, 3'd2, 4'hB, 8'h04);
    cycle(1'b0, 3'd0, 4'h0, 8'h00);
    cycle(1'b1, 3'd6, 4'h7, 8'h00);
    cycle(1'b0, 3'd0, 4'h0, 8'hFF);

    // Streaming across all channels, then back-to-back into one channel.
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 4'(i + 1), 8'hFF);
    cycle(1'b1, 3'd4, 4'h9, 8'hFF);
    cycle(1'b1, 3'd4, 4'hA, 8'hFF);
    cycle(1'b1, 3'd4, 4'hB, 8'hFF);
    cycle(1'b0, 3'd0, 4'h0, 8'hFF);

    // Reset mid-stream with channels 0 and 3 full.
    cycle(1'b1, 3'd0, 4'h5, 8'h00);
    cycle(1'b1, 3'd3, 4'h6, 8'h00);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 4'($urandom), 8'($urandom));
    end

    // Out-of-range flood on the m=6 instance drives the counter into saturation.
    for (int i = 0; i < 300; i++) cycle(1'b1, 3'd7, 4'hF, 8'hFF);
    cycle(1'b0, 3'd0, 4'h0, 8'hFF);
    cycle(1'b0, 3'd0, 4'h0, 8'hFF);
    check("drop_cnt_o saturated dut1", 32'(if6.drop_cnt_o), 32'd255);
    cycle(1'b0, 3'd0, 4'h0, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux1to8_n.md
# demux1to8_n

Registered 1-to-m demultiplexer with valid/ready handshake; the distribution counterpart of the 8-to-1 selector tree. It accepts one n-bit word per cycle on a single input channel and steers it, by `sel`, into one of m single-entry output buffers. Each output buffer drains independently through its own valid/ready pair. It sits in front of banked consumers (register banks, functional units) that the mux tree later reads back.

## Interface
- `n`, 4, data width in bits
- `address`, 3, width of `sel`
- `m`, 8, number of output channels (2 ≤ m ≤ 2**address)

- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `data_i`  in  n  input word
- `valid_i`  in  1  input word present
- `sel`  in  address  destination channel for `data_i`, sampled with `valid_i`
- `ready_o`  out  1  input accepted this cycle when high together with `valid_i`
- `data_o[0:m-1]`  out  n each  per-channel buffered word (unpacked array, index 0..m-1)
- `valid_o`  out  m  bit k: channel k buffer full
- `ready_i`  in  m  bit k: consumer k takes `data_o[k]` this cycle
- `err_o`  out  1  one-cycle pulse: previous accepted word had `sel` ≥ m
- `drop_cnt_o`  out  8  saturating count of words dropped for `sel` ≥ m

## Operation
- Per channel k: full flag `v[k]`, data register `d[k]`. `valid_o[k] = v[k]`, `data_o[k] = d[k]`.
- Drain: `valid_o[k] && ready_i[k]` → channel k word consumed this cycle.
- `ready_o` (combinational):
  - `sel` < m: `!v[sel] || ready_i[sel]`
  - `sel` ≥ m: 1 (word is discarded)
- Accept = `valid_i && ready_o`.
- On accept with `sel` = k < m: `d[k] <= data_i`, `v[k] <= 1`.
- On a channel not accepted into: if drained, `v[k] <= 0`; `d[k]` holds its value.
- Simultaneous drain and fill of the same channel: `v[k]` stays 1, `d[k]` takes the new word. No bubble.
- Out-of-range accept (`sel` ≥ m): no channel written. `err_o <= 1` for the next cycle. `drop_cnt_o` increments, saturating at 255. Out-of-range is impossible when m = 2**address; logic still required.
- `err_o <= 0` on every cycle without an out-of-range accept.
- Channels are fully independent. Full channel j never blocks an accept into channel k ≠ j.
- `valid_i` low → no state change except drains. `data_i` and `sel` are don't-care.
- `ready_o` never depends on `valid_i`. `valid_o` never depends on `ready_i` (no combinational loop).

## Timing
- Reset (`rst_ni` low, asynchronous): `v` = 0, all `d[k]` = 0, `err_o` = 0, `drop_cnt_o` = 0. So `valid_o` = 0 and all `data_o` = 0 immediately, without waiting for a clock edge.
- Reset mid-operation: buffered words are lost. The first accept after `rst_ni` rises is taken at the first rising edge with `rst_ni` high.
- Latency: word accepted at edge t is visible on `data_o[k]` / `valid_o[k]` after edge t. It can be consumed in the cycle following edge t.
- Throughput: one word per cycle into any channel, including back-to-back to the same channel while its consumer holds `ready_i[k]` high.
- Combinational path: `ready_i` → `ready_o` through the `sel` decode.
- `err_o` asserts the cycle after the offending accept, for exactly one cycle per offending word. Consecutive offending words keep it high.

## Test plan
- Reset then route: release reset; send 0x3 to sel 5 → `valid_o` = 8'b0010_0000, `data_o[5]` = 0x3 after one edge; all other `data_o` = 0.
- Backpressure: `ready_i[2]` = 0; send 0xA to sel 2, then 0xB to sel 2 → second cycle `ready_o` = 0, `data_o[2]` stays 0xA. Raise `ready_i[2]` → 0xB accepted the same cycle, `data_o[2]` = 0xB next cycle.
- Independence: channel 2 full and stalled; send 0x7 to sel 6 → `ready_o` = 1, `data_o[6]` = 0x7.
- Streaming: all `ready_i` = 1; send 0x1..0x8 to sels 0..7 over 8 cycles, then 0x9, 0xA, 0xB to sel 4 back-to-back → `ready_o` always 1. Each word appears exactly one cycle after its accept, with no lost or duplicated drains.
- Out-of-range (m = 6, address = 3): send 0xF to sel 7 → `ready_o` = 1, no `valid_o` change, `err_o` = 1 for one cycle, `drop_cnt_o` = 1. Repeat 300 times → `drop_cnt_o` = 255.
- Async reset mid-stream: assert `rst_ni` low between edges with channels 0, 3 full → `valid_o` = 0 and `data_o` = 0 before the next edge.
